// File: rtl/led_seq_pkg.sv
// led_seq_pkg: mode encodings and ping-pong direction type for the LED sequencer.
package led_seq_pkg;
  localparam logic [1:0] MODE_LEFT     = 2'd0;
  localparam logic [1:0] MODE_RIGHT    = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  localparam logic [1:0] MODE_BLINK    = 2'd3;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
endpackage

// File: rtl/led_seq_timer.sv
// led_seq_timer: step prescaler counting 0..STEP_CYCLES-1 while run is high, ticking at terminal count.
module led_seq_timer #(
  parameter int STEP_CYCLES = 50_000_000,
  parameter int CNT_W       = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
  assign tick = run && !clr && cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (run) cnt <= cnt + 1'b1;
endmodule

// File: rtl/led_seq.sv
// led_seq: LED pattern sequencer (left, right, ping-pong, blink) stepped by a prescaler.
// Defining LED_SEQ_PWM_EN adds DUTY_W and a duty input that PWM-gates the LED drive.
module led_seq
  import led_seq_pkg::*;
#(
  parameter int LED_NUM     = 4,
  parameter int STEP_CYCLES = 50_000_000,
  parameter int CNT_W       = 32
`ifdef LED_SEQ_PWM_EN
  , parameter int DUTY_W    = 8
`endif
) (
`ifdef LED_SEQ_PWM_EN
  input  logic [DUTY_W-1:0]  duty,
`endif
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [1:0]         mode,
  output logic [LED_NUM-1:0] led,
  output logic               step,
  output logic               wrap
);
  localparam logic [LED_NUM-1:0] LSB = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] MSB = LSB << (LED_NUM - 1);
  logic [1:0] mode_q;
  logic [LED_NUM-1:0] pat, pat_nxt, pat_d, gate;
  dir_t dir, dir_nxt;
  logic fresh, tick, clr, wrap_nxt, empty;
  assign clr = mode != mode_q;
  assign empty = pat == '0;
  led_seq_timer #(.STEP_CYCLES(STEP_CYCLES), .CNT_W(CNT_W)) u_timer (
    .clk(clk), .rst_n(rst_n), .run(run), .clr(clr), .tick(tick)
  );
`ifdef LED_SEQ_PWM_EN
  logic [DUTY_W-1:0] pwm_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pwm_cnt <= '0;
    else pwm_cnt <= pwm_cnt + 1'b1;
  assign gate = {LED_NUM{pwm_cnt < duty}};
`else
  assign gate = '1;
`endif
  always_comb begin
    pat_nxt = pat;
    dir_nxt = dir;
    wrap_nxt = 1'b0;
    case (mode_q)
      MODE_LEFT: begin
        pat_nxt = empty ? LSB : {pat[LED_NUM-2:0], pat[LED_NUM-1]};
        wrap_nxt = pat[LED_NUM-1];
      end
      MODE_RIGHT: begin
        pat_nxt = empty ? MSB : {pat[0], pat[LED_NUM-1:1]};
        wrap_nxt = pat[0];
      end
      MODE_PINGPONG: begin
        // Reversing at an end never repeats it; with two LEDs the reversal itself lands on bit0.
        if (empty) begin
          pat_nxt = LSB;
          dir_nxt = DIR_UP;
        end else if (dir == DIR_UP) begin
          pat_nxt = pat[LED_NUM-1] ? pat >> 1 : pat << 1;
          dir_nxt = pat[LED_NUM-1] ? DIR_DOWN : DIR_UP;
          wrap_nxt = pat[LED_NUM-1] && pat[1];
        end else begin
          pat_nxt = pat[0] ? pat << 1 : pat >> 1;
          dir_nxt = pat[0] ? DIR_UP : DIR_DOWN;
          wrap_nxt = pat[1];
        end
      end
      default: begin
        pat_nxt = empty ? '1 : '0;
        wrap_nxt = empty && !fresh;
      end
    endcase
  end
  assign pat_d = clr ? '0 : tick ? pat_nxt : pat;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q <= MODE_LEFT;
      pat <= '0;
      led <= '0;
      dir <= DIR_UP;
      fresh <= 1'b1;
      step <= 1'b0;
      wrap <= 1'b0;
    end else begin
      mode_q <= mode;
      pat <= pat_d;
      led <= pat_d & gate;
      step <= tick;
      wrap <= tick && wrap_nxt;
      if (clr) begin
        dir <= DIR_UP;
        fresh <= 1'b1;
      end else if (tick) begin
        dir <= dir_nxt;
        fresh <= 1'b0;
      end
    end
endmodule
